vga_timing_gen: RTL and testbench

//   Upstream raster timing stage for the VGA pixel generators on the 25.125 MHz PLL pixel clock.

---
 rtl/vga_timing_pkg.sv | 41 ++++
 rtl/vga_axis_counter.sv | 57 +++++
 rtl/vga_timing_gen.sv | 170 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 raster constants, coordinate width and decode types
//
// Purpose : default VGA timing constants and a packed record of the decoded
//           timing signals, shared by the timing generator and the colour stages.
// Contents: COORD_W, VGA_* default geometry, vga_timing_t, in_span().

package vga_timing_pkg;

    // Width of every beam counter and active-area coordinate.
    localparam int COORD_W = 10;

    // 640x480@60 on a 25.125 MHz pixel clock.
    localparam int VGA_H_PIXELS = 800;
    localparam int VGA_V_LINES  = 521;
    localparam int VGA_H_PULSE  = 96;
    localparam int VGA_V_PULSE  = 2;
    localparam int VGA_H_BP     = 144;
    localparam int VGA_H_FP     = 784;
    localparam int VGA_V_BP     = 31;
    localparam int VGA_V_FP     = 511;
    localparam int VGA_FC_W     = 32;

    // Everything that is decoded from the beam position and registered together.
    typedef struct packed {
        logic               hsync;
        logic               vsync;
        logic               active;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               line_start;
        logic               frame_start;
    } vga_timing_t;

    // Half-open window test: lo <= v < hi.
    function automatic logic in_span(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrapping beam counter for one raster axis
//
// Purpose : counts 0..MAX-1, advancing when en and inc are both high.
// Ports   : clk        in   clock
//           rst        in   asynchronous active-high reset
//           en         in   global count enable
//           inc        in   advance request for this axis
//           count      out  registered count
//           count_next out  value count takes at the next edge
//           wrap       out  high in the cycle whose edge takes count from MAX-1 to 0

module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int MAX = 800
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               inc,
    output logic [COORD_W-1:0] count,
    output logic [COORD_W-1:0] count_next,
    output logic               wrap
);

    localparam logic [COORD_W-1:0] LAST = COORD_W'(MAX - 1);

    logic [COORD_W-1:0] count_q;
    logic [COORD_W-1:0] count_d;
    logic               wrap_d;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (en && inc) begin
            if (count_q == LAST) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;
    assign wrap       = wrap_d;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator (beam counters, syncs, active area, strobes)
//
// Purpose : free-running hc/vc beam counters with registered sync, active-video,
//           active-area coordinates, line/frame strobes and a frame counter.
//           Decode is taken from the next-count values so every registered
//           output describes the hc/vc it is presented with.
// Macro   : VGA_TIMING_PIPE_EN - adds one register stage on the decoded
//           outputs (syncs, active, x, y, strobes); hc, vc, frame_count stay undelayed.
// Ports   : clk          in   pixel clock
//           rst          in   asynchronous active-high reset
//           en           in   count enable, low freezes everything (strobes read 0)
//           hc, vc       out  beam counters
//           vga_hsync    out  low while hc < H_PULSE
//           vga_vsync    out  low while vc < V_PULSE
//           active       out  inside the visible window
//           x, y         out  active-area coordinates, 0 outside the window
//           line_start   out  one-cycle strobe on each hc wrap to 0
//           frame_start  out  one-cycle strobe when hc and vc both wrap to 0
//           frame_count  out  frames completed, modulo 2^FC_W

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_PIXELS = VGA_H_PIXELS,
    parameter int V_LINES  = VGA_V_LINES,
    parameter int H_PULSE  = VGA_H_PULSE,
    parameter int V_PULSE  = VGA_V_PULSE,
    parameter int H_BP     = VGA_H_BP,
    parameter int H_FP     = VGA_H_FP,
    parameter int V_BP     = VGA_V_BP,
    parameter int V_FP     = VGA_V_FP,
    parameter int FC_W     = VGA_FC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [COORD_W-1:0] hc,
    output logic [COORD_W-1:0] vc,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic               active,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
    output logic               frame_start,
    output logic [FC_W-1:0]    frame_count
);

    localparam logic [COORD_W-1:0] H_PULSE_C = COORD_W'(H_PULSE);
    localparam logic [COORD_W-1:0] V_PULSE_C = COORD_W'(V_PULSE);
    localparam logic [COORD_W-1:0] H_BP_C    = COORD_W'(H_BP);
    localparam logic [COORD_W-1:0] H_FP_C    = COORD_W'(H_FP);
    localparam logic [COORD_W-1:0] V_BP_C    = COORD_W'(V_BP);
    localparam logic [COORD_W-1:0] V_FP_C    = COORD_W'(V_FP);

    logic [COORD_W-1:0] hc_cur;
    logic [COORD_W-1:0] hc_next;
    logic               h_wrap;
    logic [COORD_W-1:0] vc_cur;
    logic [COORD_W-1:0] vc_next;
    logic               v_wrap;

    logic [FC_W-1:0]    frame_count_q;
    logic [FC_W-1:0]    frame_count_d;

    vga_timing_t        dec_d;
    vga_timing_t        dec_q;
    vga_timing_t        dec_out;

    logic               h_act;
    logic               v_act;

    vga_axis_counter #(
        .MAX        (H_PIXELS)
    ) u_h_counter (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .inc        (1'b1),
        .count      (hc_cur),
        .count_next (hc_next),
        .wrap       (h_wrap)
    );

    // The vertical axis only advances on the horizontal wrap edge.
    vga_axis_counter #(
        .MAX        (V_LINES)
    ) u_v_counter (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .inc        (h_wrap),
        .count      (vc_cur),
        .count_next (vc_next),
        .wrap       (v_wrap)
    );

    // v_wrap already implies en and h_wrap, i.e. the last pixel of the frame.
    always_comb begin
        frame_count_d = frame_count_q + {{(FC_W-1){1'b0}}, v_wrap};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    // Decode from the post-edge counter values so the registered result
    // lines up with hc/vc in the same cycle.
    always_comb begin
        dec_d             = '0;
        h_act             = in_span(hc_next, H_BP_C, H_FP_C);
        v_act             = in_span(vc_next, V_BP_C, V_FP_C);
        dec_d.hsync       = (hc_next >= H_PULSE_C);
        dec_d.vsync       = (vc_next >= V_PULSE_C);
        dec_d.active      = h_act && v_act;
        dec_d.x           = (h_act && v_act) ? (hc_next - H_BP_C) : '0;
        dec_d.y           = (h_act && v_act) ? (vc_next - V_BP_C) : '0;
        // Strobes come only from real wrap transitions, never from reset release.
        dec_d.line_start  = h_wrap;
        dec_d.frame_start = v_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q <= '0;
        end else if (en) begin
            dec_q <= dec_d;
        end else begin
            dec_q.line_start  <= 1'b0;
            dec_q.frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_PIPE_EN
    // Extra stage for colour stages that register RGB one clock after
    // sampling hc/vc; it freezes with en like the first stage.
    vga_timing_t pipe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else if (en) begin
            pipe_q <= dec_q;
        end else begin
            pipe_q.line_start  <= 1'b0;
            pipe_q.frame_start <= 1'b0;
        end
    end

    assign dec_out = pipe_q;
`else
    assign dec_out = dec_q;
`endif

    assign hc          = hc_cur;
    assign vc          = vc_cur;
    assign frame_count = frame_count_q;
    assign vga_hsync   = dec_out.hsync;
    assign vga_vsync   = dec_out.vsync;
    assign active      = dec_out.active;
    assign x           = dec_out.x;
    assign y           = dec_out.y;
    assign line_start  = dec_out.line_start;
    assign frame_start = dec_out.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized self-checking bench for vga_timing_gen against an arithmetic raster model

module tb_vga_timing_gen;

`ifdef VGA_TIMING_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;

    always #5 clk = ~clk;

    // Default 640x480 instance.
    logic [9:0]  hc_d, vc_d, x_d, y_d;
    logic        hs_d, vs_d, act_d, ls_d, fs_d;
    logic [31:0] fc_d;

    // Tiny raster so whole frames and the frame counter wrap fit in a short run.
    localparam int S_HP = 20, S_VL = 10, S_HPU = 3, S_VPU = 2;
    localparam int S_HBP = 5, S_HFP = 17, S_VBP = 3, S_VFP = 8, S_FCW = 4;
    logic [9:0]  hc_s, vc_s, x_s, y_s;
    logic        hs_s, vs_s, act_s, ls_s, fs_s;
    logic [3:0]  fc_s;

    vga_timing_gen dut (
        .clk(clk), .rst(rst), .en(en),
        .hc(hc_d), .vc(vc_d), .vga_hsync(hs_d), .vga_vsync(vs_d), .active(act_d),
        .x(x_d), .y(y_d), .line_start(ls_d), .frame_start(fs_d), .frame_count(fc_d)
    );

    vga_timing_gen #(
        .H_PIXELS(S_HP), .V_LINES(S_VL), .H_PULSE(S_HPU), .V_PULSE(S_VPU),
        .H_BP(S_HBP), .H_FP(S_HFP), .V_BP(S_VBP), .V_FP(S_VFP), .FC_W(S_FCW)
    ) dut_s (
        .clk(clk), .rst(rst), .en(en),
        .hc(hc_s), .vc(vc_s), .vga_hsync(hs_s), .vga_vsync(vs_s), .active(act_s),
        .x(x_s), .y(y_s), .line_start(ls_s), .frame_start(fs_s), .frame_count(fc_s)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: enabled edges since reset, and whether the last two edges were enabled.
    int t  = 0;
    bit e1 = 1'b0;
    bit e2 = 1'b0;

    typedef struct {
        int     hc;
        int     vc;
        longint fc;
        bit     hs;
        bit     vs;
        bit     act;
        int     x;
        int     y;
        bit     ls;
        bit     fs;
    } exp_t;

    // Raster position is simply the enabled-edge count folded by line and frame length.
    function automatic exp_t ref_model(input int hp, input int vl, input int hpu, input int vpu,
                                       input int hbp, input int hfp, input int vbp, input int vfp,
                                       input int fcw);
        exp_t e;
        int   td;
        int   dh;
        int   dv;
        e.hc = t % hp;
        e.vc = (t / hp) % vl;
        e.fc = longint'(t / (hp * vl)) & ((longint'(1) << fcw) - 1);
        td   = PIPE ? ((t > 0) ? t - 1 : 0) : t;
        dh   = td % hp;
        dv   = (td / hp) % vl;
        e.hs  = (dh >= hpu);
        e.vs  = (dv >= vpu);
        e.act = (dh >= hbp) && (dh < hfp) && (dv >= vbp) && (dv < vfp);
        e.x   = e.act ? dh - hbp : 0;
        e.y   = e.act ? dv - vbp : 0;
        e.ls  = e1 && (PIPE ? e2 : 1'b1) && (td > 0) && (dh == 0);
        e.fs  = e.ls && (dv == 0);
        return e;
    endfunction

    task automatic check_inst(input string p, input exp_t e,
                              input logic [9:0] hc, input logic [9:0] vc,
                              input logic hs, input logic vs, input logic act,
                              input logic [9:0] x, input logic [9:0] y,
                              input logic ls, input logic fs, input logic [31:0] fc);
        chk({p, ".hc"},          64'(hc),  64'(e.hc));
        chk({p, ".vc"},          64'(vc),  64'(e.vc));
        chk({p, ".hsync"},       64'(hs),  64'(e.hs));
        chk({p, ".vsync"},       64'(vs),  64'(e.vs));
        chk({p, ".active"},      64'(act), 64'(e.act));
        chk({p, ".x"},           64'(x),   64'(e.x));
        chk({p, ".y"},           64'(y),   64'(e.y));
        chk({p, ".line_start"},  64'(ls),  64'(e.ls));
        chk({p, ".frame_start"}, 64'(fs),  64'(e.fs));
        chk({p, ".frame_count"}, 64'(fc),  64'(e.fc));
    endtask

    task automatic check_all();
        check_inst("def", ref_model(800, 521, 96, 2, 144, 784, 31, 511, 32),
                   hc_d, vc_d, hs_d, vs_d, act_d, x_d, y_d, ls_d, fs_d, fc_d);
        check_inst("small", ref_model(S_HP, S_VL, S_HPU, S_VPU, S_HBP, S_HFP, S_VBP, S_VFP, S_FCW),
                   hc_s, vc_s, hs_s, vs_s, act_s, x_s, y_s, ls_s, fs_s, 32'(fc_s));
    endtask

    task automatic model_reset();
        t  = 0;
        e1 = 1'b0;
        e2 = 1'b0;
    endtask

    // One clock with the given enable; outputs are checked on the falling edge.
    task automatic step(input bit en_v);
        en = en_v;
        @(posedge clk);
        e2 = e1;
        e1 = en_v;
        if (en_v) t++;
        @(negedge clk);
        check_all();
    endtask

    int fs_seen;

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all();

        // Line 0: first edge, hsync boundary, then the first line wrap.
        step(1'b1);
        chk("hc_after_first_edge", 64'(hc_d), 64'd1);
        repeat (94) step(1'b1);
        chk("hsync_at_hc95", 64'(hs_d), 64'd0);
        step(1'b1);
        chk("hsync_at_hc96", 64'(hs_d), PIPE ? 64'd0 : 64'd1);
        repeat (703) step(1'b1);
        step(1'b1);
        chk("wrap_hc", 64'(hc_d), 64'd0);
        chk("wrap_vc", 64'(vc_d), 64'd1);
        chk("wrap_line_start", 64'(ls_d), PIPE ? 64'd0 : 64'd1);
        step(1'b1);
        chk("line_start_next", 64'(ls_d), PIPE ? 64'd1 : 64'd0);

        // Freeze for 50 clocks mid-line, then resume.
        repeat (200) step(1'b1);
        repeat (50) step(1'b0);
        chk("frozen_hc", 64'(hc_d), 64'd201);
        step(1'b1);
        chk("resume_hc", 64'(hc_d), 64'd202);

        // Randomized enable; the small instance rolls over its 4-bit frame counter.
        fs_seen = 0;
        repeat (4000) begin
            step($urandom_range(0, 7) != 0);
            if (fs_s) fs_seen++;
        end
        chk("small_frames_seen", 64'(fs_seen != 0), 64'd1);

        // Asynchronous reset in the middle of a clock period.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        check_all();

        repeat (1000) step($urandom_range(0, 3) != 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
